// File: rtl/pa_spsram_1024x36_ctrl.sv
// Single-port SRAM controller: clears the array after reset, then serves
// masked writes and in-order reads through a 2-entry credited response FIFO.
module pa_spsram_1024x36_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 36
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  rd_pending;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            fifo_cnt;
  logic [1:0]            credit;

  logic run;
  logic accept;
  logic acc_rd;
  logic acc_wr;
  logic push;
  logic pop;

  assign run     = (state == RUN) && !cpurst;
  assign rsp_vld = (fifo_cnt != 2'd0);
  assign pop     = rsp_vld && rsp_rdy;
  assign push    = rd_pending;

  // A read needs a credit so the FIFO can never overflow; a same-cycle pop frees one.
  assign req_rdy = run && (req_wr || (credit < 2'd2) || pop);
  assign accept  = req_vld && req_rdy;
  assign acc_rd  = accept && !req_wr;
  assign acc_wr  = accept && req_wr && (|req_wmask);

  assign rsp_rdata = rsp_vld ? fifo_mem[rd_ptr] : '0;

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state      <= INIT;
      init_cnt   <= '0;
      init_done  <= 1'b0;
      rd_pending <= 1'b0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fifo_cnt   <= 2'd0;
      credit     <= 2'd0;
    end else begin
      rd_pending <= acc_rd;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
      credit   <= credit + 2'(acc_rd) - 2'(pop);
      case (state)
        INIT: begin
          init_cnt <= init_cnt + ADDR_WIDTH'(1);
          if (&init_cnt) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
        end
        default: state <= INIT;
      endcase
    end
  end

  // SRAM data is captured the cycle after the read access.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst && push) fifo_mem[wr_ptr] <= sram_q;
  end

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (cpurst) begin
      sram_cen = 1'b1;
    end else if (state == INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_cnt;
    end else if (acc_wr) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = ~req_wmask;
      sram_a    = req_addr;
      sram_d    = req_wdata;
    end else if (acc_rd) begin
      sram_cen = 1'b0;
      sram_a   = req_addr;
    end
  end

endmodule

// File: doc/pa_spsram_1024x36_ctrl.md
PA_SPSRAM_1024X36_CTRL -- requirements
Module: pa_spsram_1024x36_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, SRAM address width (depth 1024).
REQ-002 SHALL have parameter DATA_WIDTH, default 36, SRAM data and bit-write-enable width.
REQ-003 SHALL have port forever_cpuclk, input, 1, the single clock; every register is clocked on its rising edge.
REQ-004 SHALL have port cpurst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port req_vld, input, 1, request valid.
REQ-006 SHALL have port req_rdy, output, 1, request accepted when req_vld&req_rdy are both high.
REQ-007 SHALL have port req_wr, input, 1, 1=write, 0=read.
REQ-008 SHALL have port req_addr, input, ADDR_WIDTH, word address.
REQ-009 SHALL have port req_wdata, input, DATA_WIDTH, write data.
REQ-010 SHALL have port req_wmask, input, DATA_WIDTH, active-high per-bit write mask.
REQ-011 SHALL have port rsp_vld, output, 1, read data valid.
REQ-012 SHALL have port rsp_rdy, input, 1, consumer ready.
REQ-013 SHALL have port rsp_rdata, output, DATA_WIDTH, read data.
REQ-014 SHALL have port init_done, output, 1, high once the clear sweep has completed.
REQ-015 SHALL have port sram_a, output, ADDR_WIDTH, SRAM address.
REQ-016 SHALL have port sram_cen, output, 1, active-low chip enable.
REQ-017 SHALL have port sram_gwen, output, 1, active-low global write enable.
REQ-018 SHALL have port sram_wen, output, DATA_WIDTH, active-low per-bit write enable.
REQ-019 SHALL have port sram_d, output, DATA_WIDTH, SRAM write data.
REQ-020 SHALL have port sram_q, input, DATA_WIDTH, SRAM read data, valid one cycle after the read access.

Function
REQ-021 SHALL implement FSM states INIT and RUN; reset enters INIT with init_cnt=0.
REQ-022 In INIT, each cycle SHALL drive sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_a=init_cnt, sram_d=0, then increment init_cnt.
REQ-023 INIT SHALL transition to RUN in the cycle after writing address 1023 (1024 cycles); init_cnt SHALL NOT wrap back into a second sweep.
REQ-024 init_done SHALL be 0 in INIT and 1 in RUN; req_rdy SHALL be 0 in INIT.
REQ-025 SRAM outputs SHALL be combinational from the accepted request so that the SRAM samples them on the same rising edge as the handshake.
REQ-026 Idle SRAM outputs (no access) SHALL be: sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0.
REQ-027 An accepted write SHALL drive sram_cen=0, sram_gwen=0, sram_wen=~req_wmask, sram_a=req_addr, sram_d=req_wdata, and SHALL produce no response.
REQ-028 An accepted write with req_wmask=0 SHALL be consumed with no SRAM access (sram_cen=1).
REQ-029 An accepted read SHALL drive sram_cen=0, sram_gwen=1, sram_wen=all 1, sram_a=req_addr.
REQ-030 For an accepted read, sram_q SHALL be pushed into a 2-entry response FIFO one cycle after acceptance.
REQ-031 Read latency SHALL be 2 cycles from acceptance to rsp_vld when the FIFO is empty: the SRAM read occupies one cycle and the FIFO registers sram_q.
REQ-032 Responses SHALL be returned in request order.
REQ-033 The controller SHALL keep a credit count = reads in flight + FIFO occupancy, range 0..2.
REQ-034 In RUN, req_rdy SHALL be 1 for a write; for a read it SHALL be 1 only if credit count < 2 or a FIFO pop occurs in the same cycle.
REQ-035 A simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-036 rsp_rdata SHALL equal the FIFO head; the FIFO SHALL pop on rsp_vld&rsp_rdy.
REQ-037 When the FIFO is empty, rsp_rdata SHALL be 0.
REQ-038 The controller SHALL NOT forward write data to reads (the SRAM is the single point of ordering); a read following a write to the same address in the next cycle SHALL return the new data.

Reset
REQ-039 Reset SHALL force: FSM=INIT, init_cnt=0, FIFO empty, credit=0, rsp_vld=0, rsp_rdata=0, init_done=0, req_rdy=0.
REQ-040 SRAM outputs SHALL be driven to their idle values (REQ-026) while cpurst=1.
REQ-041 Reset asserted mid-INIT or mid-RUN SHALL discard in-flight reads and buffered responses, then restart the clear sweep from address 0.

Verification
REQ-042 Release reset, hold req_vld=1 -> sweep writes 0 to addresses 0..1023 with sram_wen=all 0; init_done rises in cycle 1025; req_rdy=0 throughout the sweep.
REQ-043 After init: write addr 5, data 36'h123456789, mask all 1, then read addr 5 -> rsp_vld 2 cycles after the read is accepted, rsp_rdata=36'h123456789.
REQ-044 Partial write mask 36'h0000000FF, data 36'hFFFFFFFFF, to cleared addr 7; read addr 7 -> rsp_rdata=36'h0000000FF and sram_wen=36'hFFFFFFF00 on the write.
REQ-045 rsp_rdy=0, issue 3 back-to-back reads -> first two accepted, third stalls with req_rdy=0; pulse rsp_rdy for one cycle -> third read accepted in that same cycle; order preserved.
REQ-046 Reset asserted at init_cnt=500 -> next cycle sram_a=0; init_done first rises 1025 cycles after deassertion.
REQ-047 Write with req_wmask=0 -> accepted, sram_cen stays 1, no rsp_vld.
